// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI SRAM responder.
package spi_pkg;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
  localparam int         SPI_ADDR_BYTES = 2;
  localparam int         SPI_ADDR_BITS  = SPI_ADDR_BYTES * 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_IGNORE = 3'd5
  } spi_state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Brings sclk/cs_n/mosi into the clk domain and flags sclk edges.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [2:0] w_in;
  logic [2:0] w_sync;
  logic       r_sclk_prev;

  assign w_in = {mosi, cs_n, sclk};

  // cs_n chains reset to "selected" so a post-reset cs_n that is already
  // low never looks like a fresh high->low transition.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [NS-1:0] r_chain;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_chain <= '0;
        end else begin
          r_chain <= {r_chain[NS-2:0], w_in[gi]};
        end
      end
      assign w_sync[gi] = r_chain[NS-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_prev <= w_sync[0];
    end
  end

  assign sclk_rise = w_sync[0] & ~r_sclk_prev;
  assign sclk_fall = ~w_sync[0] & r_sclk_prev;
  assign cs_n_s    = w_sync[1];
  assign mosi_s    = w_sync[2];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 sequential-mode SRAM responder with a backdoor port.
module spi_sram_responder
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 2 ** ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              busy,
  output logic              cmd_err,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata,
  input  logic              bd_clr
);

  logic w_rise, w_fall, w_cs_n_s, w_mosi_s;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sclk_rise(w_rise),
    .sclk_fall(w_fall),
    .cs_n_s   (w_cs_n_s),
    .mosi_s   (w_mosi_s)
  );

  spi_state_t                 r_state;
  logic [4:0]                 r_bit_cnt;
  logic [SPI_ADDR_BITS-2:0]   r_shreg;
  logic [7:0]                 r_out_sh;
  logic [ADDR_W-1:0]          r_addr;
  logic                       r_is_read;
  logic                       r_armed;
  logic                       r_miso;
  logic                       r_cmd_err;
  logic [7:0]                 r_mem [DEPTH];
  logic [7:0]                 r_rd_q;
  logic [7:0]                 r_bd_rdata;

  logic [SPI_ADDR_BITS-1:0]   w_shift_in;
  logic                       w_spi_we;
  logic                       w_bd_we;
  logic [7:0]                 w_out_byte;
  logic [ADDR_W-1:0]          w_addr_next;

  assign w_shift_in  = {r_shreg, w_mosi_s};
  assign w_spi_we    = (r_state == ST_WRITE) && !w_cs_n_s && w_rise && (r_bit_cnt == 5'd7);
  assign w_bd_we     = bd_we && !(w_spi_we && (bd_addr == r_addr));
  assign w_addr_next = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
  // r_rd_q tracks mem[r_addr] one cycle behind; falls are far enough apart
  // that it is always current when a new byte starts shifting out.
  assign w_out_byte  = (r_bit_cnt == 5'd0) ? r_rd_q : r_out_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_out_sh  <= '0;
      r_addr    <= '0;
      r_is_read <= 1'b0;
      r_armed   <= 1'b0;
      r_miso    <= 1'b0;
      r_cmd_err <= 1'b0;
    end else begin
      if (bd_clr) begin
        r_cmd_err <= 1'b0;
      end
      if (w_cs_n_s) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        r_armed   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_armed) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (w_rise) begin
              r_shreg <= w_shift_in[SPI_ADDR_BITS-2:0];
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                if (w_shift_in[7:0] == SPI_CMD_READ) begin
                  r_state   <= ST_ADDR;
                  r_is_read <= 1'b1;
                end else if (w_shift_in[7:0] == SPI_CMD_WRITE) begin
                  r_state   <= ST_ADDR;
                  r_is_read <= 1'b0;
                end else begin
                  r_state   <= ST_IGNORE;
                  r_cmd_err <= 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_shreg <= w_shift_in[SPI_ADDR_BITS-2:0];
              if (r_bit_cnt == 5'(SPI_ADDR_BITS - 1)) begin
                r_bit_cnt <= '0;
                r_addr    <= w_shift_in[ADDR_W-1:0];
                r_state   <= r_is_read ? ST_READ : ST_WRITE;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_READ: begin
            if (w_fall) begin
              r_miso   <= w_out_byte[7];
              r_out_sh <= {w_out_byte[6:0], 1'b0};
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                r_addr    <= w_addr_next;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_WRITE: begin
            if (w_rise) begin
              r_shreg <= w_shift_in[SPI_ADDR_BITS-2:0];
              if (r_bit_cnt == 5'd7) begin
                r_bit_cnt <= '0;
                r_addr    <= w_addr_next;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_IGNORE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // SPI write takes precedence when both ports hit the same byte.
  always_ff @(posedge clk) begin
    if (w_spi_we) begin
      r_mem[r_addr] <= w_shift_in[7:0];
    end
    if (w_bd_we) begin
      r_mem[bd_addr] <= bd_wdata;
    end
    r_rd_q <= r_mem[r_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bd_rdata <= '0;
    end else begin
      r_bd_rdata <= r_mem[bd_addr];
    end
  end

  assign miso     = r_miso;
  assign busy     = (r_state != ST_IDLE);
  assign cmd_err  = r_cmd_err;
  assign bd_rdata = r_bd_rdata;

endmodule
